// File: rtl/arbitrating_multiplexor_pkg.sv
// Shared constants and helpers for the channel mux/demux pair.
package arbitrating_multiplexor_pkg;

  // Number of channels addressed by an index of the given width.
  function automatic int unsigned chan_count(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

  // Channel idx occupies [slice_lsb(idx, dw) +: dw] of a packed channel bus.
  function automatic int unsigned slice_lsb(input int unsigned idx, input int unsigned dw);
    return idx * dw;
  endfunction

endpackage

// File: rtl/arbitrating_multiplexor_round_robin_arbiter.sv
// Combinational round-robin grant: first requester at or after ptr, wrapping.
module arbitrating_multiplexor_round_robin_arbiter
  import arbitrating_multiplexor_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 2
) (
  input  logic [chan_count(ADDRESS_WIDTH)-1:0] req,
  input  logic [ADDRESS_WIDTH-1:0]             ptr,
  output logic                                 grant_valid,
  output logic [ADDRESS_WIDTH-1:0]             grant
);

  localparam int unsigned N = chan_count(ADDRESS_WIDTH);

  logic [ADDRESS_WIDTH-1:0] idx;

  // Scan farthest offset first so the nearest requester after ptr wins last.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    idx         = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      idx = ptr + ADDRESS_WIDTH'(i);
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant       = idx;
      end
    end
  end

endmodule

// File: rtl/arbitrating_multiplexor.sv
// Merges N valid/ready channels onto one registered output stream, tagged by source.
module arbitrating_multiplexor
  import arbitrating_multiplexor_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 2,
  parameter int unsigned DATA_WIDTH    = 8
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic [chan_count(ADDRESS_WIDTH)-1:0]            in_valid,
  input  logic [chan_count(ADDRESS_WIDTH)*DATA_WIDTH-1:0] in_data,
  output logic [chan_count(ADDRESS_WIDTH)-1:0]            in_ready,
  output logic                                            out_valid,
  output logic [DATA_WIDTH-1:0]                           out_data,
  output logic [ADDRESS_WIDTH-1:0]                        out_address,
  input  logic                                            out_ready
);

  localparam int unsigned N = chan_count(ADDRESS_WIDTH);

  logic [ADDRESS_WIDTH-1:0] ptr;
  logic                     grant_valid;
  logic [ADDRESS_WIDTH-1:0] grant;
  logic                     load_en;
  logic [DATA_WIDTH-1:0]    chan_data [N];

  for (genvar i = 0; i < int'(N); i++) begin : g_unpack
    assign chan_data[i] = in_data[slice_lsb(i, DATA_WIDTH) +: DATA_WIDTH];
  end

  arbitrating_multiplexor_round_robin_arbiter #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_arbiter (
    .req         (in_valid),
    .ptr         (ptr),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  // Register is empty or draining this cycle; allows drain and load together.
  assign load_en = !out_valid || out_ready;

  always_comb begin
    in_ready = '0;
    if (grant_valid && load_en && !reset) begin
      in_ready = N'(1) << grant;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_address <= '0;
      ptr         <= '0;
    end else if (load_en) begin
      if (grant_valid) begin
        out_valid   <= 1'b1;
        out_data    <= chan_data[grant];
        out_address <= grant;
        ptr         <= grant + ADDRESS_WIDTH'(1);
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arbitrating_multiplexor.sv
// Directed bench for arbitrating_multiplexor with hand-computed expectations.
module tb_arbitrating_multiplexor;

  localparam int unsigned AW = 2;
  localparam int unsigned DW = 8;
  localparam int unsigned N  = 4;

  logic            clk;
  logic            reset;
  logic [N-1:0]    in_valid;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [AW-1:0]   out_address;
  logic            out_ready;

  int total = 0;
  int bad   = 0;

  arbitrating_multiplexor #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_address (out_address),
    .out_ready   (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int ch, input logic [DW-1:0] v);
    in_data[ch*DW +: DW] = v;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [DW-1:0] d,
                           input logic [AW-1:0] a);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".data"}, 32'(out_data), 32'(d));
    check({tag, ".addr"}, 32'(out_address), 32'(a));
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    in_data   = '0;
    for (int i = 0; i < int'(N); i++) set_data(i, DW'(8'h10 + i));

    // Reset holds in_ready low even with requests pending.
    tick();
    #1;
    check("rst_in_ready", 32'(in_ready), 32'h0);
    tick();
    in_valid = 4'b0000;
    reset    = 1'b0;
    #1;
    check_out("after_reset", 1'b0, 8'h00, 2'd0);
    check("idle_in_ready", 32'(in_ready), 32'h0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check_out("idle", 1'b0, 8'h00, 2'd0);
    end

    // Single channel 2.
    set_data(2, 8'hA5);
    in_valid = 4'b0100;
    #1;
    check("single_in_ready", 32'(in_ready), 32'b0100);
    tick();
    in_valid = 4'b0000;
    check_out("single", 1'b1, 8'hA5, 2'd2);
    tick();
    check_out("no_grant_hold", 1'b0, 8'hA5, 2'd2);

    // ptr should now be 3: with 1011 valid, channel 3 wins.
    set_data(2, 8'h12);
    in_valid = 4'b1011;
    #1;
    check("ptr3_in_ready", 32'(in_ready), 32'b1000);
    tick();
    check_out("ptr3", 1'b1, 8'h13, 2'd3);

    // Fairness with all channels valid, back-to-back.
    in_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("rr_in_ready", 32'(in_ready), 32'(4'b0001 << (k % 4)));
      tick();
      check_out("rr", 1'b1, DW'(8'h10 + (k % 4)), AW'(k % 4));
    end

    // Load 0x3C from channel 1 (ptr is 2, only ch1 valid).
    set_data(1, 8'h3C);
    in_valid = 4'b0010;
    #1;
    check("bp_load_in_ready", 32'(in_ready), 32'b0010);
    tick();
    check_out("bp_load", 1'b1, 8'h3C, 2'd1);

    // Backpressure: everything holds.
    out_ready = 1'b0;
    in_valid  = 4'b1111;
    set_data(1, 8'h11);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_in_ready", 32'(in_ready), 32'h0);
      tick();
      check_out("bp_hold", 1'b1, 8'h3C, 2'd1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 32'(in_ready), 32'b0100);
    tick();
    check_out("bp_release", 1'b1, 8'h12, 2'd2);

    // Wrap and skip from ptr=3.
    in_valid = 4'b0011;
    #1;
    check("wrap0_in_ready", 32'(in_ready), 32'b0001);
    tick();
    check_out("wrap0", 1'b1, 8'h10, 2'd0);
    check("wrap1_in_ready", 32'(in_ready), 32'b0010);
    tick();
    check_out("wrap1", 1'b1, 8'h11, 2'd1);
    in_valid = 4'b0001;
    #1;
    check("skip_in_ready", 32'(in_ready), 32'b0001);
    tick();
    check_out("skip", 1'b1, 8'h10, 2'd0);

    // Reset while stalled on 0x77.
    set_data(0, 8'h77);
    #1;
    tick();
    check_out("pre_rst", 1'b1, 8'h77, 2'd0);
    out_ready = 1'b0;
    in_valid  = 4'b0000;
    tick();
    check_out("stall77", 1'b1, 8'h77, 2'd0);
    reset     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 4'b0001;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'h0);
    tick();
    reset    = 1'b0;
    in_valid = 4'b0000;
    check_out("midrst", 1'b0, 8'h00, 2'd0);
    tick();
    check_out("post_rst", 1'b0, 8'h00, 2'd0);
    in_valid = 4'b1111;
    #1;
    check("post_rst_ptr0", 32'(in_ready), 32'b0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
